// File: rtl/hazard_if.sv
// Hazard controller bus: pipeline hazard sources in, stage-register controls
// and performance counters out.
interface hazard_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       ex_rd;
    logic             ex_mem_read;
    logic             ex_redirect;
    logic             ex_mc_start;
    logic             ex_mc_done;
    logic             cnt_clr;
    logic             pc_we;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_we;
    logic             idex_flush;
    logic             exmem_flush;
    logic             mc_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Pipeline side: drives hazard sources, consumes controls.
    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               ex_redirect, ex_mc_start, ex_mc_done, cnt_clr,
        input  pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_flush,
               mc_timeout, stall_cnt, flush_cnt
    );

    // Hazard controller side.
    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               ex_redirect, ex_mc_start, ex_mc_done, cnt_clr,
        output pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_flush,
               mc_timeout, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, EX redirect flushes and
// multi-cycle EX freezes with a fixed priority, plus stall/flush counters.
module hazard_ctrl #(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic     clk,
    input  logic     rst,
    hazard_if.slave  bus
);
    localparam int             BW      = $clog2(MC_TIMEOUT) + 1;
    localparam logic [BW-1:0]  TMO_VAL = BW'(MC_TIMEOUT);
    localparam logic [BW-1:0]  CTR_ONE = {{(BW-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MC_BUSY = 1'b1
    } state_t;

    state_t           fsm_r, fsm_nxt_s;
    logic [BW-1:0]    busy_ctr_r, busy_ctr_nxt_s;
    logic             mc_timeout_r, tmo_set_s;
    logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;

    logic load_use_s, mc_hold_s, timeout_hit_s, redirect_take_s;
    logic pc_we_s, ifid_we_s, ifid_flush_s, idex_we_s, idex_flush_s, exmem_flush_s;

    // Hazard detection; a timed-out wait is treated as if the op finished.
    always_comb begin
        load_use_s = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                     ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                      (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));
        timeout_hit_s = (fsm_r == MC_BUSY) && (busy_ctr_r == TMO_VAL) && !bus.ex_mc_done;
        mc_hold_s = ((fsm_r == MC_BUSY) || bus.ex_mc_start) && !bus.ex_mc_done && !timeout_hit_s;
        redirect_take_s = 1'b0;
        if (rst) begin
            redirect_take_s = 1'b0;
        end else if (!mc_hold_s && bus.ex_redirect) begin
            redirect_take_s = 1'b1;
        end else begin
            redirect_take_s = 1'b0;
        end
    end

    // Stage-register controls: reset override, then hold > redirect > load-use.
    always_comb begin
        pc_we_s       = 1'b1;
        ifid_we_s     = 1'b1;
        ifid_flush_s  = 1'b0;
        idex_we_s     = 1'b1;
        idex_flush_s  = 1'b0;
        exmem_flush_s = 1'b0;
        if (rst) begin
            pc_we_s       = 1'b0;
            ifid_we_s     = 1'b0;
            idex_we_s     = 1'b0;
            ifid_flush_s  = 1'b1;
            idex_flush_s  = 1'b1;
            exmem_flush_s = 1'b1;
        end else if (mc_hold_s) begin
            pc_we_s       = 1'b0;
            ifid_we_s     = 1'b0;
            idex_we_s     = 1'b0;
            exmem_flush_s = 1'b1;
        end else if (redirect_take_s) begin
            pc_we_s       = 1'b1;
            ifid_flush_s  = 1'b1;
            idex_flush_s  = 1'b1;
        end else if (load_use_s) begin
            pc_we_s       = 1'b0;
            ifid_we_s     = 1'b0;
            idex_flush_s  = 1'b1;
        end else begin
            pc_we_s       = 1'b1;
        end
    end

    // Multi-cycle wait FSM next state and busy counter.
    always_comb begin
        fsm_nxt_s      = fsm_r;
        busy_ctr_nxt_s = busy_ctr_r;
        tmo_set_s      = 1'b0;
        case (fsm_r)
            RUN: begin
                if (bus.ex_mc_start && !bus.ex_mc_done) begin
                    fsm_nxt_s      = MC_BUSY;
                    busy_ctr_nxt_s = CTR_ONE;
                end else begin
                    fsm_nxt_s      = RUN;
                end
            end
            MC_BUSY: begin
                if (bus.ex_mc_done) begin
                    fsm_nxt_s      = RUN;
                end else if (timeout_hit_s) begin
                    fsm_nxt_s      = RUN;
                    tmo_set_s      = 1'b1;
                end else begin
                    busy_ctr_nxt_s = busy_ctr_r + CTR_ONE;
                end
            end
            default: begin
                fsm_nxt_s      = RUN;
                busy_ctr_nxt_s = {BW{1'b0}};
            end
        endcase
    end

    // State, sticky timeout flag and performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_r        <= RUN;
            busy_ctr_r   <= {BW{1'b0}};
            mc_timeout_r <= 1'b0;
            stall_cnt_r  <= {CNT_W{1'b0}};
            flush_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            fsm_r        <= fsm_nxt_s;
            busy_ctr_r   <= busy_ctr_nxt_s;
            mc_timeout_r <= mc_timeout_r | tmo_set_s;
            if (bus.cnt_clr) begin
                stall_cnt_r <= {CNT_W{1'b0}};
                flush_cnt_r <= {CNT_W{1'b0}};
            end else begin
                if (!pc_we_s) begin
                    stall_cnt_r <= stall_cnt_r + CNT_ONE;
                end
                if (redirect_take_s) begin
                    flush_cnt_r <= flush_cnt_r + CNT_ONE;
                end
            end
        end
    end

    assign bus.pc_we       = pc_we_s;
    assign bus.ifid_we     = ifid_we_s;
    assign bus.ifid_flush  = ifid_flush_s;
    assign bus.idex_we     = idex_we_s;
    assign bus.idex_flush  = idex_flush_s;
    assign bus.exmem_flush = exmem_flush_s;
    assign bus.mc_timeout  = mc_timeout_r;
    assign bus.stall_cnt   = stall_cnt_r;
    assign bus.flush_cnt   = flush_cnt_r;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl (MC_TIMEOUT = 8).
module tb_hazard_ctrl;
    localparam int CNT_W = 32;

    // Control vector order: {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_flush}
    localparam logic [5:0] C_DEF   = 6'b110100;
    localparam logic [5:0] C_HOLD  = 6'b000001;
    localparam logic [5:0] C_REDIR = 6'b111110;
    localparam logic [5:0] C_LU    = 6'b000110;
    localparam logic [5:0] C_RST   = 6'b001011;

    typedef struct {
        string            tag;
        logic [5:0]       ctrl;
        logic [CNT_W-1:0] stall;
        logic [CNT_W-1:0] flush;
        logic             tmo;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    hazard_if #(.CNT_W(CNT_W)) hif ();

    hazard_ctrl #(.MC_TIMEOUT(8), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (hif.slave)
    );

    always #5 clk = ~clk;

    exp_t             sb[$];
    int               total = 0;
    int               bad   = 0;
    logic [CNT_W-1:0] m_stall = '0;
    logic [CNT_W-1:0] m_flush = '0;
    logic             m_tmo   = 1'b0;

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic mr, input logic redir, input logic start,
                         input logic done, input logic clr);
        hif.id_rs1      = rs1;
        hif.id_rs2      = rs2;
        hif.id_use_rs1  = u1;
        hif.id_use_rs2  = u2;
        hif.ex_rd       = rd;
        hif.ex_mem_read = mr;
        hif.ex_redirect = redir;
        hif.ex_mc_start = start;
        hif.ex_mc_done  = done;
        hif.cnt_clr     = clr;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // One clock: predict, push, check controls mid-cycle, check state after the edge.
    task automatic step(input string tag, input logic [5:0] ctrl, input logic tmo_set);
        exp_t e;
        exp_t g;
        logic [5:0] obs;
        if (rst) begin
            m_stall = '0;
            m_flush = '0;
            m_tmo   = 1'b0;
        end else begin
            if (hif.cnt_clr) begin
                m_stall = '0;
                m_flush = '0;
            end else begin
                if (!ctrl[5]) m_stall = m_stall + 32'd1;
                if (ctrl == C_REDIR) m_flush = m_flush + 32'd1;
            end
            m_tmo = m_tmo | tmo_set;
        end
        e.tag = tag; e.ctrl = ctrl; e.stall = m_stall; e.flush = m_flush; e.tmo = m_tmo;
        sb.push_back(e);
        @(negedge clk);
        g = sb.pop_front();
        obs = {hif.pc_we, hif.ifid_we, hif.ifid_flush, hif.idex_we, hif.idex_flush, hif.exmem_flush};
        total++;
        assert (obs === g.ctrl) else begin
            bad++;
            $error("FAIL %s ctrl: got %b want %b", g.tag, obs, g.ctrl);
        end
        @(posedge clk);
        #1;
        total++;
        assert (hif.stall_cnt === g.stall) else begin
            bad++;
            $error("FAIL %s stall_cnt: got %0d want %0d", g.tag, hif.stall_cnt, g.stall);
        end
        total++;
        assert (hif.flush_cnt === g.flush) else begin
            bad++;
            $error("FAIL %s flush_cnt: got %0d want %0d", g.tag, hif.flush_cnt, g.flush);
        end
        total++;
        assert (hif.mc_timeout === g.tmo) else begin
            bad++;
            $error("FAIL %s mc_timeout: got %b want %b", g.tag, hif.mc_timeout, g.tmo);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        step("reset0", C_RST, 1'b0);
        step("reset1", C_RST, 1'b0);
        rst = 1'b0;
        step("idle", C_DEF, 1'b0);

        // Load-use on rs2
        drive(5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("load_use_rs2", C_LU, 1'b0);
        // Load-use on rs1
        drive(5'd9, 5'd2, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("load_use_rs1", C_LU, 1'b0);
        // x0 is never a dependency
        drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("x0_no_stall", C_DEF, 1'b0);
        // Matching register but operand not used
        drive(5'd7, 5'd3, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("unused_rs1", C_DEF, 1'b0);
        // Match without a load
        drive(5'd7, 5'd3, 1'b1, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("no_load", C_DEF, 1'b0);
        // Redirect wins over load-use
        drive(5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step("redir_over_lu", C_REDIR, 1'b0);

        // Multi-cycle op: start for 4 cycles, done in the 4th, redirect in cycle 2 ignored
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("mc_c1", C_HOLD, 1'b0);
        drive(5'd6, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step("mc_c2_redir", C_HOLD, 1'b0);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("mc_c3", C_HOLD, 1'b0);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step("mc_c4_done", C_DEF, 1'b0);
        idle();
        step("mc_after", C_DEF, 1'b0);

        // Start and done together: no stall
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step("mc_same_cycle", C_DEF, 1'b0);
        idle();
        step("after_same", C_DEF, 1'b0);

        // Redirect alone
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("redir_alone", C_REDIR, 1'b0);

        // Timeout: 8 hold cycles then the forced-done cycle raises mc_timeout
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step($sformatf("tmo_hold%0d", i), C_HOLD, 1'b0);
        end
        step("tmo_hit", C_DEF, 1'b1);
        idle();
        step("tmo_sticky", C_DEF, 1'b0);

        // cnt_clr during a load-use stall: zeroed, no increment; timeout flag survives
        drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step("clr_in_stall", C_LU, 1'b0);
        idle();
        step("after_clr", C_DEF, 1'b0);

        // Reset in the middle of MC_BUSY
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("busy_a", C_HOLD, 1'b0);
        step("busy_b", C_HOLD, 1'b0);
        rst = 1'b1;
        step("rst_in_busy", C_RST, 1'b0);
        rst = 1'b0;
        idle();
        step("run_after_rst", C_DEF, 1'b0);

        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
